// File: rtl/lsu_sequencer_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_sequencer_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam int FUNCT3_W = 3;

  // RV32I load/store funct3 encodings.
  localparam logic [FUNCT3_W-1:0] LSU_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LSU_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LSU_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LSU_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_sequencer_align.sv
// Combinational byte-lane logic: legality, alignment, write mask/data placement
// and load-data realignment with sign/zero extension.
module lsu_align
  import lsu_sequencer_pkg::*;
(
  input  logic                is_store,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [1:0]          off,
  input  logic [31:0]         wdata_in,
  input  logic [31:0]         rdata_in,
  output logic                legal,
  output logic                misaligned,
  output logic [3:0]          wmask,
  output logic [31:0]         wdata_out,
  output logic [31:0]         rdata_out
);

  logic [31:0] sh;

  // Decode access size from funct3 and steer bytes between lane and LSB positions.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    wmask      = 4'b0000;
    sh         = rdata_in >> {off, 3'b000};
    wdata_out  = wdata_in << {off, 3'b000};
    rdata_out  = 32'h0;
    case (funct3)
      LSU_B: begin
        legal     = 1'b1;
        wmask     = 4'b0001 << off;
        rdata_out = {{24{sh[7]}}, sh[7:0]};
      end
      LSU_H: begin
        legal      = 1'b1;
        misaligned = off[0];
        wmask      = 4'b0011 << off;
        rdata_out  = {{16{sh[15]}}, sh[15:0]};
      end
      LSU_W: begin
        legal      = 1'b1;
        misaligned = |off;
        wmask      = 4'b1111;
        rdata_out  = sh;
      end
      LSU_BU: begin
        // Unsigned variants exist only for loads.
        legal     = ~is_store;
        wmask     = 4'b0001 << off;
        rdata_out = {24'h0, sh[7:0]};
      end
      LSU_HU: begin
        legal      = ~is_store;
        misaligned = off[0];
        wmask      = 4'b0011 << off;
        rdata_out  = {16'h0, sh[15:0]};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: accepts one command from the core, issues a single
// word-aligned memory transaction, and returns the extended load result with a done pulse.
module lsu_sequencer
  import lsu_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_is_store,
  input  logic [FUNCT3_W-1:0] cmd_funct3,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_wdata,
  output logic                stall,
  output logic                done,
  output logic                err,
  output logic [31:0]         rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_wmask,
  output logic [31:0]         mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  lsu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_store_q, is_store_d;
  logic [FUNCT3_W-1:0] funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [3:0]          mem_wmask_q, mem_wmask_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  // The aligner sees the live command while idle (for accept/reject and lane placement)
  // and the latched command afterwards (for realigning the returned word).
  logic                in_idle;
  logic                al_is_store;
  logic [FUNCT3_W-1:0] al_funct3;
  logic [1:0]          al_off;
  logic                al_legal, al_misaligned;
  logic [3:0]          al_wmask;
  logic [31:0]         al_wdata, al_rdata;

  assign in_idle     = (state_q == S_IDLE);
  assign al_is_store = in_idle ? cmd_is_store   : is_store_q;
  assign al_funct3   = in_idle ? cmd_funct3     : funct3_q;
  assign al_off      = in_idle ? cmd_addr[1:0]  : off_q;

  lsu_align u_align (
    .is_store   (al_is_store),
    .funct3     (al_funct3),
    .off        (al_off),
    .wdata_in   (cmd_wdata),
    .rdata_in   (mem_rdata),
    .legal      (al_legal),
    .misaligned (al_misaligned),
    .wmask      (al_wmask),
    .wdata_out  (al_wdata),
    .rdata_out  (al_rdata)
  );

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

  // Next-state, command capture, handshake and timeout control.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wmask_d   = mem_wmask_q;
    mem_wdata_d   = mem_wdata_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    stall         = 1'b0;
    done          = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = cmd_valid;
        if (cmd_valid) begin
          rdata_d = 32'h0;
          if (al_legal && !al_misaligned) begin
            state_d     = S_ISSUE;
            is_store_d  = cmd_is_store;
            funct3_d    = cmd_funct3;
            off_d       = cmd_addr[1:0];
            mem_we_d    = cmd_is_store;
            mem_addr_d  = {cmd_addr[31:2], 2'b00};
            mem_wmask_d = al_wmask;
            mem_wdata_d = al_wdata;
            err_d       = 1'b0;
          end else begin
            // Rejected commands never touch memory.
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = is_store_q ? 32'h0 : al_rdata;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        // Stall drops here so the core retires the instruction on this edge.
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
